// File: rtl/recv_shift_if.sv
// Serial receive bus bundle: transaction control, serial data in, byte/handshake
// and status outputs. The receiver uses the slave side, its driver the master side.
interface recv_shift_if;
  logic       start;
  logic [1:0] len;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    output start, len, rx_in, rx_ack,
    input  rx_data, rx_valid, busy, done, overrun
  );

  modport slave (
    input  start, len, rx_in, rx_ack,
    output rx_data, rx_valid, busy, done, overrun
  );
endinterface

// File: rtl/recv_shift.sv
// Serial-to-parallel receiver: shifts 1..4 bytes off rx_in while start is held,
// presents each completed byte with a valid/ack handshake and a sticky overrun flag.
module recv_shift #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  recv_shift_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [1:0] r_byte_cnt;
  logic [1:0] r_len;
  logic [7:0] r_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_overrun;

  logic [7:0] w_shift_next;
  logic       w_complete;

  // The bit on rx_in is folded into the byte on the same edge it is sampled.
  assign w_shift_next = MSB_FIRST ? {r_shift[6:0], bus.rx_in}
                                  : {bus.rx_in, r_shift[7:1]};
  assign w_complete   = (r_state == S_SHIFT) && bus.start && (r_bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 2'd0;
      r_len      <= 2'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift    <= w_shift_next;
            r_len      <= bus.len;
            r_byte_cnt <= 2'd0;
            r_overrun  <= 1'b0;
            r_bit_cnt  <= 3'd1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!bus.start) begin
            r_state <= S_IDLE;
          end else begin
            r_shift <= w_shift_next;
            if (w_complete) begin
              r_bit_cnt <= 3'd0;
              if (r_byte_cnt == r_len) begin
                r_state <= S_DONE;
              end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A completing byte always wins over an ack; an ack on that edge only spares overrun.
      if (w_complete) begin
        r_rx_data  <= w_shift_next;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !bus.rx_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && bus.rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.overrun  = r_overrun;
  assign bus.busy     = (r_state == S_SHIFT);
  assign bus.done     = (r_state == S_DONE);

endmodule

// File: tb/tb_recv_shift.sv
// Bench for recv_shift: MSB-first and LSB-first instances share one stimulus stream
// and are checked against a transaction-level model, a vector table and directed sequences.
module tb_recv_shift;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       start  = 1'b0;
  logic [1:0] len    = 2'd0;
  logic       rx_in  = 1'b0;
  logic       rx_ack = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  recv_shift_if if_m ();
  recv_shift_if if_l ();

  assign if_m.start  = start;
  assign if_m.len    = len;
  assign if_m.rx_in  = rx_in;
  assign if_m.rx_ack = rx_ack;
  assign if_l.start  = start;
  assign if_l.len    = len;
  assign if_l.rx_in  = rx_in;
  assign if_l.rx_ack = rx_ack;

  recv_shift #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));
  recv_shift #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));

  typedef struct {
    logic       start;
    logic [1:0] len;
    logic       rx_in;
    logic       rx_ack;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl [10];

  // Transaction-level reference: collected bits of the current byte, byte count, handshake flags.
  int         m_phase = 0;   // 0 idle, 1 receiving, 2 finished
  bit         m_bits[$];
  int         m_len = 0;
  int         m_cnt = 0;
  logic [7:0] m_dm = 8'h00;
  logic [7:0] m_dl = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovr = 1'b0;

  function automatic logic [11:0] pk(logic [7:0] d, logic v, logic b, logic dn, logic o);
    return {d, v, b, dn, o};
  endfunction

  function automatic logic [11:0] act_m();
    return pk(if_m.rx_data, if_m.rx_valid, if_m.busy, if_m.done, if_m.overrun);
  endfunction

  function automatic logic [11:0] act_l();
    return pk(if_l.rx_data, if_l.rx_valid, if_l.busy, if_l.done, if_l.overrun);
  endfunction

  task automatic cmp(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_bits.delete();
    m_len   = 0;
    m_cnt   = 0;
    m_dm    = 8'h00;
    m_dl    = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_edge();
    bit         complete;
    logic [7:0] vm;
    logic [7:0] vl;
    complete = 1'b0;
    vm = 8'h00;
    vl = 8'h00;
    case (m_phase)
      0: begin
        if (start) begin
          m_bits.delete();
          m_bits.push_back(rx_in);
          m_len   = int'(len);
          m_cnt   = 0;
          m_ovr   = 1'b0;
          m_phase = 1;
        end
      end
      1: begin
        if (!start) begin
          m_phase = 0;
        end else begin
          m_bits.push_back(rx_in);
          if (m_bits.size() == 8) begin
            complete = 1'b1;
            for (int k = 0; k < 8; k++) begin
              if (m_bits[k]) begin
                vm = vm + 8'(1 << (7 - k));
                vl = vl + 8'(1 << k);
              end
            end
            m_bits.delete();
            if (m_cnt == m_len) m_phase = 2;
            else m_cnt++;
          end
        end
      end
      default: begin
        if (!start) m_phase = 0;
      end
    endcase
    if (complete) begin
      if (m_valid && !rx_ack) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_dm    = vm;
      m_dl    = vl;
    end else if (m_valid && rx_ack) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_model(input string nm);
    cmp({nm, "/msb"}, act_m(), pk(m_dm, m_valid, m_phase == 1, m_phase == 2, m_ovr));
    cmp({nm, "/lsb"}, act_l(), pk(m_dl, m_valid, m_phase == 1, m_phase == 2, m_ovr));
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    model_edge();
    #1;
    check_model(nm);
  endtask

  task automatic send_byte(input logic [7:0] b, input string nm);
    for (int i = 0; i < 8; i++) begin
      start = 1'b1;
      rx_in = b[7 - i];
      tick(nm);
    end
  endtask

  // Reset asserted between edges must clear the outputs before any clock arrives.
  task automatic async_reset(input string nm);
    #2 rst_n = 1'b0;
    start  = 1'b0;
    rx_ack = 1'b0;
    #1;
    model_reset();
    check_model(nm);
    cmp({nm, "/zero"}, act_m(), 12'h000);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b3 [3];
    logic [7:0] got [$];
    int         edges;

    // Single byte 8'hA5, MSB first, then release start with an ack.
    tbl[0] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 2'd0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 2'd0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};

    async_reset("reset0");
    check_model("reset0_rel");

    for (int i = 0; i < 10; i++) begin
      start  = tbl[i].start;
      len    = tbl[i].len;
      rx_in  = tbl[i].rx_in;
      rx_ack = tbl[i].rx_ack;
      @(posedge clk);
      model_edge();
      #1;
      cmp($sformatf("tbl%0d", i), act_m(),
          pk(tbl[i].exp_data, tbl[i].exp_valid, tbl[i].exp_busy, tbl[i].exp_done, tbl[i].exp_ovr));
      check_model($sformatf("tbl%0d", i));
    end
    cmp("palindrome_lsb", {4'h0, if_l.rx_data}, 12'h0A5);

    // 8'h01 on the wire: MSB-first sees 01, LSB-first sees 80.
    rx_ack = 1'b0;
    len    = 2'd0;
    send_byte(8'h01, "b01");
    cmp("b01_msb", act_m(), pk(8'h01, 1'b1, 1'b0, 1'b1, 1'b0));
    cmp("b01_lsb", act_l(), pk(8'h80, 1'b1, 1'b0, 1'b1, 1'b0));
    start  = 1'b0;
    rx_ack = 1'b1;
    tick("b01_end");
    rx_ack = 1'b0;

    // Three back-to-back bytes, acked after each one shows up.
    b3[0] = 8'h12;
    b3[1] = 8'h34;
    b3[2] = 8'h56;
    len   = 2'd2;
    edges = 0;
    for (int k = 0; k < 24; k++) begin
      start = 1'b1;
      rx_in = b3[k / 8][7 - (k % 8)];
      if (if_m.busy || (!if_m.done && start)) edges++;
      tick("three");
      if (if_m.rx_valid && !rx_ack) begin
        got.push_back(if_m.rx_data);
        rx_ack = 1'b1;
      end else begin
        rx_ack = 1'b0;
      end
    end
    cmp("three_edges", 12'(edges), 12'd24);
    cmp("three_count", 12'(got.size()), 12'd3);
    for (int j = 0; j < 3; j++) begin
      cmp($sformatf("three_byte%0d", j), {4'h0, (j < got.size()) ? got[j] : 8'hxx}, {4'h0, b3[j]});
    end
    cmp("three_ovr", {11'h0, if_m.overrun}, 12'h000);
    start = 1'b0;
    tick("three_end");
    rx_ack = 1'b0;

    // Two bytes without ack: second overwrites, overrun sticks until the next start.
    len = 2'd1;
    send_byte(8'h12, "ovr_b0");
    send_byte(8'h34, "ovr_b1");
    cmp("ovr_set", act_m(), pk(8'h34, 1'b1, 1'b0, 1'b1, 1'b1));
    start = 1'b0;
    tick("ovr_hold");
    cmp("ovr_sticky", {11'h0, if_m.overrun}, 12'h001);
    start = 1'b1;
    rx_in = 1'b0;
    tick("ovr_restart");
    cmp("ovr_clear", act_m(), pk(8'h34, 1'b1, 1'b1, 1'b0, 1'b0));

    // Abort after four bits: partial byte dropped, byte and valid untouched.
    for (int k = 0; k < 3; k++) begin
      rx_in = 1'b1;
      tick("abort_bits");
    end
    start = 1'b0;
    tick("abort");
    cmp("abort_state", act_m(), pk(8'h34, 1'b1, 1'b0, 1'b0, 1'b0));
    tick("abort_idle");
    cmp("abort_no_done", {11'h0, if_m.done}, 12'h000);
    rx_ack = 1'b1;
    tick("abort_ack");
    rx_ack = 1'b0;

    // Ack coinciding with the second completion: no overrun, valid stays up.
    len = 2'd1;
    send_byte(8'hAB, "same_b0");
    for (int i = 0; i < 8; i++) begin
      logic [7:0] cd;
      cd     = 8'hCD;
      start  = 1'b1;
      rx_in  = cd[7 - i];
      rx_ack = (i == 7);
      tick("same_b1");
    end
    cmp("same_edge", act_m(), pk(8'hCD, 1'b1, 1'b0, 1'b1, 1'b0));
    rx_ack = 1'b0;
    start  = 1'b0;
    tick("same_end");

    // Reset pulsed in the middle of a byte.
    len = 2'd0;
    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      rx_in = 1'b1;
      tick("rst_bits");
    end
    async_reset("rst_mid");
    tick("rst_after");

    // Randomized traffic against the reference.
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 11) == 0) start = ~start;
      len    = 2'($urandom_range(0, 3));
      rx_in  = 1'($urandom_range(0, 1));
      rx_ack = ($urandom_range(0, 3) == 0);
      tick($sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/recv_shift.md
RECV_SHIFT -- requirements
Module: recv_shift

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, selecting bit order: 1 = first sampled bit lands in rx_data[7]; 0 = first sampled bit lands in rx_data[0].
REQ-002 SHALL have port clk  input  1  single clock; all sampling and state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  transaction enable level; held high for the whole transaction.
REQ-005 SHALL have port len  input  2  bytes to receive minus 1 (0 -> 1 byte, 3 -> 4 bytes); captured at transaction start.
REQ-006 SHALL have port rx_in  input  1  serial data from peripheral; changes on negedge clk.
REQ-007 SHALL have port rx_data  output  8  last completed byte.
REQ-008 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_ack  input  1  consumer accepts rx_data this cycle.
REQ-010 SHALL have port busy  output  1  high while in SHIFT.
REQ-011 SHALL have port done  output  1  high while in DONE.
REQ-012 SHALL have port overrun  output  1  sticky: a completed byte overwrote an unacknowledged byte.

Function
REQ-013 SHALL implement states IDLE, SHIFT, DONE; bit counter 3 bits; byte counter 2 bits; shift register 8 bits.
REQ-014 IDLE with start=1 at a posedge: SHALL sample rx_in as bit 1 of the byte on that same edge, capture len, clear byte counter, clear overrun, set bit counter to 1, go to SHIFT.
REQ-015 SHIFT: SHALL sample one bit per posedge; the 8th sample of a byte completes it with no extra cycle of latency.
REQ-016 On byte completion, at the same edge: rx_data SHALL load the assembled byte (including the bit just sampled) and rx_valid SHALL be set to 1.
REQ-017 On byte completion with bytes remaining: SHALL stay in SHIFT, reset bit counter to 0, increment byte counter; the next edge samples the next byte's first bit with no gap.
REQ-018 On completion of byte len: SHALL go to DONE.
REQ-019 DONE SHALL hold while start=1 and go to IDLE on the first posedge with start=0; a new transaction requires start low for at least one edge.
REQ-020 start=0 in SHIFT: SHALL abort to IDLE; the partial byte is discarded; rx_data and rx_valid are unchanged; done is not asserted.
REQ-021 Handshake: rx_valid=1 and rx_ack=1 at a posedge with no completion SHALL clear rx_valid; rx_ack with rx_valid=0 SHALL be ignored.
REQ-022 Completion with rx_valid=1 and rx_ack=0: SHALL overwrite rx_data, keep rx_valid=1, and set overrun.
REQ-023 Completion with rx_valid=1 and rx_ack=1 at the same edge: SHALL load the new byte, keep rx_valid=1, and leave overrun unchanged.
REQ-024 overrun SHALL stay set until the next transaction start (REQ-014) or reset.
REQ-025 busy and done SHALL be registered outputs, decoded directly from the state register.

Reset
REQ-026 On rst_n=0, asynchronously: state IDLE; counters 0; shift register 0; rx_data=8'h00; rx_valid=0; busy=0; done=0; overrun=0.
REQ-027 Reset release SHALL take effect at the first posedge after rst_n goes high; reset asserted mid-transaction SHALL abandon the transaction with no rx_valid pulse.

Verification
REQ-028 Single byte, MSB_FIRST=1, len=0, serial 1,0,1,0,0,1,0,1 -> after the 8th edge: rx_data=8'hA5, rx_valid=1, done=1, busy=0.
REQ-029 MSB_FIRST=0, same bit stream -> rx_data=8'hA5 bit-reversed, i.e. 8'hA5 (palindrome check); repeat with 8'h01 stream -> rx_data=8'h80.
REQ-030 len=2, bytes 8'h12, 8'h34, 8'h56 with rx_ack pulsed after each rx_valid -> three bytes in order, overrun=0, exactly 24 busy-plus-start edges.
REQ-031 len=1, no rx_ack -> rx_data=8'h34 after the second byte, overrun=1; overrun clears at the next start.
REQ-032 start dropped after 4 bits -> state IDLE, done never high, rx_valid unchanged; rst_n pulsed mid-byte -> all outputs 0 asynchronously.
REQ-033 rx_ack asserted on the same edge as the second byte's completion -> rx_valid stays 1, rx_data = second byte, overrun=0.
